// File: rtl/dsp_preadd_mac_pipe_if.sv
// Operand/result bundle for the pipelined pre-add MAC.
// The master drives operands and control; the slave (the MAC) returns results.
interface dsp_preadd_mac_pipe_if #(
  parameter int AW = 25,
  parameter int BW = 18,
  parameter int PW = 48
);
  logic                 ce;
  logic                 in_valid;
  logic [1:0]           op;
  logic signed [AW-1:0] data_A;
  logic signed [AW-1:0] data_D;
  logic signed [BW-1:0] data_B;
  logic signed [PW-1:0] data_C;
  logic                 carry_in;
  logic signed [PW-1:0] data_P;
  logic                 out_valid;
  logic                 ovf;

  modport master (
    output ce, in_valid, op, data_A, data_D, data_B, data_C, carry_in,
    input  data_P, out_valid, ovf
  );

  modport slave (
    input  ce, in_valid, op, data_A, data_D, data_B, data_C, carry_in,
    output data_P, out_valid, ovf
  );
endinterface

// File: rtl/dsp_preadd_mac_pipe.sv
// Three-stage pre-adder MAC: P = (D +/- A) * B + X + carry_in, where X is C
// or the previous P (accumulate). Shaped to map onto one DSP slice with
// input, multiplier and output registers.
module dsp_preadd_mac_pipe #(
  parameter int AW = 25,
  parameter int BW = 18,
  parameter int PW = 48    // must be >= AW+1+BW
) (
  input logic                     clk,
  input logic                     rst_n,
  dsp_preadd_mac_pipe_if.slave    bus
);

  localparam int PAW = AW + 1;        // pre-adder width, never wraps
  localparam int MW  = AW + 1 + BW;   // full-precision product width

  // Stage 1 registers
  logic signed [AW-1:0] r_a;
  logic signed [AW-1:0] r_d;
  logic signed [BW-1:0] r_b;
  logic signed [PW-1:0] r_c1;
  logic [1:0]           r_op1;
  logic                 r_cin1;
  logic                 r_v1;

  // Stage 2 registers
  logic signed [MW-1:0] r_m;
  logic                 r_acc2;
  logic signed [PW-1:0] r_c2;
  logic                 r_cin2;
  logic                 r_v2;

  // Stage 3 (output) registers
  logic signed [PW-1:0] r_p;
  logic                 r_ovf;
  logic                 r_out_valid;

  // Combinational datapath
  logic signed [PAW-1:0] w_pa;
  logic signed [PW-1:0]  w_mx;
  logic signed [PW-1:0]  w_x;
  logic signed [PW-1:0]  w_sum;
  logic                  w_ovf;

  // Pre-add in AW+1 bits so D-A / D+A of extreme operands stays exact.
  assign w_pa = r_op1[0] ? (PAW'(r_d) - PAW'(r_a)) : (PAW'(r_d) + PAW'(r_a));

  // Feedback comes straight from the output register, so back-to-back
  // accumulates see the freshly written sum without any forwarding.
  assign w_mx  = PW'(r_m);
  assign w_x   = r_acc2 ? r_p : r_c2;
  assign w_sum = w_mx + w_x + {{(PW-1){1'b0}}, r_cin2};

  // Overflow judged on the two main addends; carry_in is not a sign source.
  assign w_ovf = (w_mx[PW-1] == w_x[PW-1]) && (w_sum[PW-1] != w_mx[PW-1]);

  // Stage 1: capture operands every enabled cycle; valid bit gates later effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_d    <= '0;
      r_b    <= '0;
      r_c1   <= '0;
      r_op1  <= '0;
      r_cin1 <= 1'b0;
      r_v1   <= 1'b0;
    end else if (bus.ce) begin
      r_a    <= bus.data_A;
      r_d    <= bus.data_D;
      r_b    <= bus.data_B;
      r_c1   <= bus.data_C;
      r_op1  <= bus.op;
      r_cin1 <= bus.carry_in;
      r_v1   <= bus.in_valid;
    end
  end

  // Stage 2: register the full-precision product and carry the addend controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m    <= '0;
      r_acc2 <= 1'b0;
      r_c2   <= '0;
      r_cin2 <= 1'b0;
      r_v2   <= 1'b0;
    end else if (bus.ce) begin
      r_m    <= MW'(w_pa) * MW'(r_b);
      r_acc2 <= r_op1[1];
      r_c2   <= r_c1;
      r_cin2 <= r_cin1;
      r_v2   <= r_v1;
    end
  end

  // Stage 3: final add; result and flag only move for valid ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.ce) begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_p   <= w_sum;
        r_ovf <= w_ovf;
      end
    end
  end

  assign bus.data_P    = r_p;
  assign bus.ovf       = r_ovf;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_dsp_preadd_mac_pipe.sv
// Scoreboard bench for dsp_preadd_mac_pipe: directed ops push expected
// results; a negedge monitor pops and checks value, flag and latency.
module tb_dsp_preadd_mac_pipe;

  localparam int AW = 25;
  localparam int BW = 18;
  localparam int PW = 48;

  logic clk;
  logic rst_n;

  dsp_preadd_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus ();

  dsp_preadd_mac_pipe #(.AW(AW), .BW(BW), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                name;
    logic signed [PW-1:0] p;
    logic                 ovf;
    int                   issue;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   ce_edges = 0;

  // Count enabled edges so latency can be measured in ce-cycles.
  always @(posedge clk) begin
    if (rst_n && bus.ce) ce_edges++;
  end

  // Monitor: consume a result on every ce-high cycle showing out_valid.
  always @(negedge clk) begin
    if (rst_n && bus.ce && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_result: got P=%0d ovf=%0b, required no output", bus.data_P, bus.ovf);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        tests_run++;
        if (bus.data_P !== e.p) begin
          tests_failed++;
          $display("FAIL %s_P: got %0d, required %0d", e.name, bus.data_P, e.p);
        end
        tests_run++;
        if (bus.ovf !== e.ovf) begin
          tests_failed++;
          $display("FAIL %s_ovf: got %0b, required %0b", e.name, bus.ovf, e.ovf);
        end
        tests_run++;
        if (ce_edges - e.issue != 3) begin
          tests_failed++;
          $display("FAIL %s_latency: got %0d, required 3", e.name, ce_edges - e.issue);
        end
        $display("[TB] %s: P=%0d ovf=%0b", e.name, bus.data_P, bus.ovf);
      end
    end
  end

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] req);
    tests_run++;
    if (got !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, $signed(got), $signed(req));
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic signed [AW-1:0] a, input logic signed [AW-1:0] d,
                       input logic signed [BW-1:0] b, input logic signed [PW-1:0] c,
                       input logic cin);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.op       = op;
    bus.data_A   = a;
    bus.data_D   = d;
    bus.data_B   = b;
    bus.data_C   = c;
    bus.carry_in = cin;
  endtask

  task automatic issue(input string name, input logic [1:0] op,
                       input logic signed [AW-1:0] a, input logic signed [AW-1:0] d,
                       input logic signed [BW-1:0] b, input logic signed [PW-1:0] c,
                       input logic cin, input logic signed [PW-1:0] ep, input logic eo);
    exp_t e;
    drive(1'b1, op, a, d, b, c, cin);
    e.name  = name;
    e.p     = ep;
    e.ovf   = eo;
    e.issue = ce_edges;
    sb_q.push_back(e);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  localparam logic signed [PW-1:0] C_MAX = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [PW-1:0] C_MIN = 48'sh8000_0000_0000;

  // Watchdog: never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.ce       = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.data_A   = '0;
    bus.data_D   = '0;
    bus.data_B   = '0;
    bus.data_C   = '0;
    bus.carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_P", bus.data_P, '0);
    check("reset_out_valid", {47'd0, bus.out_valid}, '0);
    check("reset_ovf", {47'd0, bus.ovf}, '0);
    rst_n = 1'b1;

    // Add then subtract pre-add modes.
    issue("add", 2'b00, 25'sd3, 25'sd10, -18'sd4, 48'sd100, 1'b0, 48'sd48, 1'b0);
    issue("sub", 2'b01, 25'sd3, 25'sd10, -18'sd4, 48'sd100, 1'b0, 48'sd72, 1'b0);
    // Pre-add must not wrap at AW bits.
    issue("preadd_width", 2'b00, 25'sd16777215, 25'sd16777215, 18'sd1, 48'sd0, 1'b0,
          48'sd33554430, 1'b0);
    // Most negative D minus most positive A times most negative B.
    issue("full_product", 2'b01, 25'sd16777215, -25'sd16777216, -18'sd131072, 48'sd0, 1'b0,
          48'sd4398046380032, 1'b0);
    // Accumulate chain: C ignored in accumulate mode.
    issue("acc0", 2'b00, 25'sd1, 25'sd1, 18'sd5, 48'sd0, 1'b0, 48'sd10, 1'b0);
    issue("acc1", 2'b10, 25'sd1, 25'sd1, 18'sd5, 48'sd1000, 1'b0, 48'sd20, 1'b0);
    issue("acc2", 2'b10, 25'sd1, 25'sd1, 18'sd5, 48'sd1000, 1'b0, 48'sd30, 1'b0);
    bubbles(2);
    issue("acc3", 2'b10, 25'sd1, 25'sd1, 18'sd5, 48'sd1000, 1'b0, 48'sd40, 1'b0);
    // Signed overflow then a clean result (ovf not sticky).
    issue("ovf_set", 2'b00, 25'sd0, 25'sd1, 18'sd1, C_MAX, 1'b0, C_MIN, 1'b1);
    issue("ovf_clr", 2'b00, 25'sd0, 25'sd1, 18'sd1, 48'sd5, 1'b0, 48'sd6, 1'b0);
    bubbles(5);

    // ce stall right after capture.
    issue("ce_stall", 2'b00, 25'sd2, 25'sd3, 18'sd4, 48'sd1, 1'b1, 48'sd22, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ce       = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.ce = 1'b1;
    bubbles(6);

    // Reset mid-flight: three ops in the pipe, the first just landed in P.
    drive(1'b1, 2'b00, 25'sd0, 25'sd1, 18'sd1, C_MAX, 1'b0);
    drive(1'b1, 2'b00, 25'sd1, 25'sd2, 18'sd3, 48'sd7, 1'b0);
    drive(1'b1, 2'b10, 25'sd4, 25'sd4, 18'sd4, 48'sd9, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_P", bus.data_P, C_MIN);
    check("pre_reset_ovf", {47'd0, bus.ovf}, 48'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midreset_P", bus.data_P, '0);
    check("midreset_out_valid", {47'd0, bus.out_valid}, '0);
    check("midreset_ovf", {47'd0, bus.ovf}, '0);
    #1;
    rst_n = 1'b1;
    bubbles(5);
    issue("post_reset_acc", 2'b10, 25'sd0, 25'sd2, 18'sd3, 48'sd77, 1'b0, 48'sd6, 1'b0);
    bubbles(6);

    check("scoreboard_drained", 48'(sb_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dsp_preadd_mac_pipe.md
Name: dsp_preadd_mac_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle pre-adder DSP wrapper.
- Computes P = (D ± A) * B + X, where X is either the C input or the previous result (accumulate mode).
- Pipeline: three register stages, valid tracking, global clock enable, full-width pre-adder (no pre-add wrap), per-result signed overflow flag.
- Serves as the MAC primitive for the polynomial-multiply and decapsulation datapaths; maps onto one DSP slice with AREG/DREG=1, MREG=1, PREG=1.

Parameters:
- AW, 25, width of A and D (signed).
- BW, 18, width of B (signed).
- PW, 48, width of C and P (signed); must satisfy PW >= AW+1+BW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable. 0 freezes every register, including the valid pipeline.
- in_valid  in  1  the operands on this cycle form an operation.
- op  in  2  operation select:
  - bit0: 0 = D+A, 1 = D−A.
  - bit1: 0 = add C, 1 = add the accumulator (P register).
- data_A  in  AW  signed operand.
- data_D  in  AW  signed operand.
- data_B  in  BW  signed multiplicand.
- data_C  in  PW  signed addend.
- carry_in  in  1  added at LSB of the final sum.
- data_P  out  PW  signed result register.
- out_valid  out  1  data_P holds a new result this cycle.
- ovf  out  1  signed overflow of the final add for the result in data_P.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage registers, data_P, out_valid and ovf clear to 0 immediately, independent of clk and ce. On release, the pipeline is empty.
- Stage S1 (when ce=1): register A, D, B, C, op, carry_in, in_valid. Operands are captured even when in_valid=0; only the valid bit gates later effects.
- Stage S2 (when ce=1):
  - Pre-add: pa = D + A or D − A, computed in AW+1 bits with sign extension, so it never wraps.
  - Register m = pa * B as a full-precision signed product of AW+1+BW bits.
  - Propagate op[1], C, carry_in and valid.
- Stage S3 (when ce=1 and s2_valid=1):
  - Addend X = C if op[1]=0, else the current data_P.
  - data_P <= sext(m) + X + carry_in, modulo 2^PW.
  - ovf <= 1 when sext(m) and X have the same sign and the result sign differs; else 0.
- Stage S3 (when ce=1 and s2_valid=0): data_P and ovf hold; out_valid <= 0.
- out_valid: registered copy of s2_valid, advanced only when ce=1.
- Latency: a valid op presented at edge n (ce=1 throughout) gives out_valid=1 and its result after edge n+3.
- Throughput: one op per ce-cycle.
- Accumulation chaining:
  - Back-to-back accumulate ops chain correctly with no hazard, because the feedback source is data_P itself.
  - Bubbles (in_valid=0) between accumulate ops do not disturb the accumulator.
  - An accumulate op issued immediately after reset accumulates onto 0.
  - Starting a fresh sum requires op[1]=0 with C as the initial value.
- ce=0: all state holds, including out_valid. A result that is valid stays asserted and is not duplicated; downstream must sample on ce=1 cycles only.
- Wrap-around: the final sum wraps modulo 2^PW; ovf is the only indication. ovf is not sticky.
- Reset asserted mid-operation discards all in-flight ops. The first out_valid after release comes 3 ce-cycles after the first post-reset valid op.

Test Plan:
- Add/sub: A=3, D=10, B=−4, C=100, op=00 → after 3 cycles P=48, out_valid=1, ovf=0. Next cycle with op=01 → P=72.
- Pre-add width: D=A=2^24−1, B=1, C=0, op=00 → P=33554430. No pre-add wrap (the old single-cycle wrapper gave −2).
- Accumulate chain on consecutive cycles:
  - op=00: A=1, D=1, B=5, C=0 → P=10.
  - op=10: same A, D, B → P=20.
  - op=10: same A, D, B → P=30.
  - Then insert 2 bubbles followed by one op=10 → P=40. out_valid pattern is 1,1,1,0,0,1.
- Overflow: C=2^47−1, A=0, D=1, B=1, op=00 → P=−2^47 (0x8000_0000_0000), ovf=1. Next op with C=5 and the same other operands → P=6, ovf=0.
- ce stall: issue op (A=2, D=3, B=4, C=1, carry_in=1) and drop ce for 4 cycles after the first edge → result P=22 appears exactly 3 ce-high edges after issue; out_valid asserted for one ce-high cycle only.
- Reset mid-flight: issue 3 valid ops, pulse rst_n low between clock edges → P=0, out_valid=0 and ovf=0 immediately. No stale result emerges. A new op=10 with A=0, D=2, B=3 gives P=6.
